and4_in_cond: RTL

//  - Input conditioner directly upstream of the 4-input AND gate: takes four raw, asynchronous,

---
 rtl/and4_in_cond.sv | 119 +++++++++++
 1 files changed

// File: rtl/and4_in_cond.sv
// Four-channel input conditioner feeding a 4-input AND gate: 2-flop sync plus saturating debounce per channel.
// Optional edge-pulse outputs (rise/fall) are built when AND4_IN_COND_EDGE_EN is defined.
module and4_in_cond #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_raw,
  input  logic       b_raw,
  input  logic       c_raw,
  input  logic       d_raw,
  output logic       a_q,
  output logic       b_q,
  output logic       c_q,
  output logic       d_q,
`ifdef AND4_IN_COND_EDGE_EN
  output logic [3:0] rise,
  output logic [3:0] fall,
`endif
  output logic       all_stable
);

  localparam int unsigned NCH = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit order everywhere is {d, c, b, a}.
  logic [NCH-1:0]   raw_w;
  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   s2_q, s2_d;
  logic [NCH-1:0]   lvl_q, lvl_d;
  logic [NCH-1:0]   pending_w;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  assign raw_w = {d_raw, c_raw, b_raw, a_raw};

  // Synchronizer: straight flop-to-flop, nothing between s1 and s2.
  always_comb begin
    s1_d = raw_w;
    s2_d = s1_q;
  end

  // Debounce: the level flips only after DB_CYCLES consecutive mismatching samples;
  // any matching sample clears the count, so glitches never accumulate.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pending_w[i] = (cnt_q[i] != '0);
    end
  end

  assign all_stable = ~|pending_w;

  assign a_q = lvl_q[0];
  assign b_q = lvl_q[1];
  assign c_q = lvl_q[2];
  assign d_q = lvl_q[3];

`ifdef AND4_IN_COND_EDGE_EN
  logic [NCH-1:0] rise_q, rise_d;
  logic [NCH-1:0] fall_q, fall_d;

  // Pulses are high during the first cycle the new level is visible on the q outputs.
  always_comb begin
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule
